// File: rtl/rf_scoreboard.sv
// rf_scoreboard
//   Register-file hazard controller for a 5-stage in-order pipeline.
//   It keeps a small pending-writer counter per architectural register.
//   - A counter increments when a writer issues from ID to EX.
//   - A counter decrements when WB retires the register write.
//   ID stalls while either of these holds:
//   - a source operand has a pending writer;
//   - the destination counter is saturated.
//   Register r0 is never tracked.
//
// State table
//   (no FSM; the state is the counter array plus inflight and sb_error)
//
// Ports
//   clk, reset        clock, synchronous active-high reset
//   id_*              instruction currently held in ID
//   ex_allowin        EX can accept an instruction this cycle
//   id_stall          ID must hold (combinational)
//   id_issue          ID->EX transfer fires (combinational)
//   wb_*              retiring instruction in WB
//   inflight          registered count of tracked writers in flight
//   sb_error          sticky, set on a retire with no pending writer
module rf_scoreboard #(
    parameter int NUM_REGS = 32,
    parameter int CNT_W    = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       id_valid,
    input  logic       id_use_rj,
    input  logic [4:0] id_rj,
    input  logic       id_use_rk,
    input  logic [4:0] id_rk,
    input  logic       id_rf_we,
    input  logic [4:0] id_dest,
    input  logic       ex_allowin,
    output logic       id_stall,
    output logic       id_issue,
    input  logic       wb_valid,
    input  logic       wb_rf_we,
    input  logic [4:0] wb_dest,
    output logic [3:0] inflight,
    output logic       sb_error
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] r_cnt [NUM_REGS];
    logic [3:0]       r_inflight;
    logic             r_sb_error;

    logic [CNT_W-1:0] w_cnt_j;
    logic [CNT_W-1:0] w_cnt_k;
    logic [CNT_W-1:0] w_cnt_dest;
    logic [CNT_W-1:0] w_cnt_wb;
    logic             w_hazard_j;
    logic             w_hazard_k;
    logic             w_dest_full;
    logic             w_stall;
    logic             w_issue;
    logic             w_inc;
    logic             w_dec;
    logic             w_same;
    logic             w_under;
    logic             w_dec_eff;

    always_comb begin
        w_cnt_j    = r_cnt[id_rj];
        w_cnt_k    = r_cnt[id_rk];
        w_cnt_dest = r_cnt[id_dest];
        w_cnt_wb   = r_cnt[wb_dest];
    end

    // A source stays hazardous through its retire cycle. There is no
    // forwarding, so the register file only holds the new value one cycle later.
    assign w_hazard_j  = id_use_rj & (id_rj != 5'd0) & (w_cnt_j != '0);
    assign w_hazard_k  = id_use_rk & (id_rk != 5'd0) & (w_cnt_k != '0);
    assign w_dest_full = id_rf_we & (id_dest != 5'd0) & (w_cnt_dest == CNT_MAX);
    assign w_stall     = id_valid & (w_hazard_j | w_hazard_k | w_dest_full);
    assign w_issue     = id_valid & ~w_stall & ex_allowin;

    assign w_inc   = w_issue & id_rf_we & (id_dest != 5'd0);
    assign w_dec   = wb_valid & wb_rf_we & (wb_dest != 5'd0);
    // Issue and retire on the same register cancel, so that counter is left alone.
    assign w_same  = w_inc & w_dec & (id_dest == wb_dest);
    // A retire with nothing pending is an error. It does not touch any count.
    assign w_under   = w_dec & ~w_same & (w_cnt_wb == '0);
    assign w_dec_eff = w_dec & ~w_under;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_cnt[i] <= '0;
            end
            r_inflight <= 4'd0;
            r_sb_error <= 1'b0;
        end else begin
            if (!w_same) begin
                if (w_inc) begin
                    r_cnt[id_dest] <= w_cnt_dest + 1'b1;
                end
                if (w_dec_eff) begin
                    r_cnt[wb_dest] <= w_cnt_wb - 1'b1;
                end
            end
            if (w_under) begin
                r_sb_error <= 1'b1;
            end
            case ({w_inc, w_dec_eff})
                2'b10:   r_inflight <= r_inflight + 4'd1;
                2'b01:   r_inflight <= r_inflight - 4'd1;
                default: r_inflight <= r_inflight;
            endcase
        end
    end

    assign id_stall = w_stall;
    assign id_issue = w_issue;
    assign inflight = r_inflight;
    assign sb_error = r_sb_error;

endmodule

// File: tb/tb_rf_scoreboard.sv
module tb_rf_scoreboard;

    logic       clk = 1'b0;
    logic       reset;
    logic       id_valid, id_use_rj, id_use_rk, id_rf_we, ex_allowin;
    logic [4:0] id_rj, id_rk, id_dest;
    logic       wb_valid, wb_rf_we;
    logic [4:0] wb_dest;
    logic       id_stall, id_issue, sb_error;
    logic [3:0] inflight;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    rf_scoreboard #(.NUM_REGS(32), .CNT_W(2)) dut (
        .clk(clk), .reset(reset),
        .id_valid(id_valid), .id_use_rj(id_use_rj), .id_rj(id_rj),
        .id_use_rk(id_use_rk), .id_rk(id_rk),
        .id_rf_we(id_rf_we), .id_dest(id_dest), .ex_allowin(ex_allowin),
        .id_stall(id_stall), .id_issue(id_issue),
        .wb_valid(wb_valid), .wb_rf_we(wb_rf_we), .wb_dest(wb_dest),
        .inflight(inflight), .sb_error(sb_error)
    );

    typedef struct {
        logic       rst;
        logic       idv;
        logic       urj;
        logic [4:0] rj;
        logic       urk;
        logic [4:0] rk;
        logic       we;
        logic [4:0] dest;
        logic       exa;
        logic       wbv;
        logic [4:0] wbd;
        logic       e_stall;
        logic       e_issue;
        int         e_infl;   // -1: not checked
        logic       e_err;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(input logic rst, input logic idv,
                                input logic urj, input int rj,
                                input logic urk, input int rk,
                                input logic we, input int dest, input logic exa,
                                input logic wbv, input int wbd,
                                input logic e_stall, input logic e_issue,
                                input int e_infl, input logic e_err);
        vec_t v;
        v.rst = rst; v.idv = idv; v.urj = urj; v.rj = 5'(rj);
        v.urk = urk; v.rk = 5'(rk); v.we = we; v.dest = 5'(dest);
        v.exa = exa; v.wbv = wbv; v.wbd = 5'(wbd);
        v.e_stall = e_stall; v.e_issue = e_issue;
        v.e_infl = e_infl; v.e_err = e_err;
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        reset = v.rst; id_valid = v.idv;
        id_use_rj = v.urj; id_rj = v.rj; id_use_rk = v.urk; id_rk = v.rk;
        id_rf_we = v.we; id_dest = v.dest; ex_allowin = v.exa;
        wb_valid = v.wbv; wb_rf_we = v.wbv; wb_dest = v.wbd;
    endtask

    initial begin
        vec_t idle;
        idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, -1, 0);

        // Columns: rst idv urj rj urk rk we dest exa wbv wbd | stall issue infl err
        vq.push_back(mk(0,1, 1,5, 1,6,  1,4, 1, 0,0,  0,1,0,0));  // add r4,r5,r6
        vq.push_back(mk(0,1, 1,4, 0,0,  0,0, 1, 0,0,  1,0,1,0));  // reader r4 stalls
        vq.push_back(mk(0,1, 1,4, 0,0,  0,0, 1, 1,4,  1,0,1,0));  // still stalled in retire cycle
        vq.push_back(mk(0,1, 1,4, 0,0,  0,0, 1, 0,0,  0,1,0,0));  // released
        vq.push_back(mk(0,1, 1,0, 1,0,  1,7, 1, 0,0,  0,1,0,0));  // r7 writer #1
        vq.push_back(mk(0,1, 0,0, 0,0,  1,7, 1, 0,0,  0,1,1,0));  // #2
        vq.push_back(mk(0,1, 0,0, 0,0,  1,7, 1, 0,0,  0,1,2,0));  // #3
        vq.push_back(mk(0,1, 0,0, 0,0,  1,7, 1, 0,0,  1,0,3,0));  // #4 dest_full
        vq.push_back(mk(0,1, 0,0, 0,0,  1,7, 1, 1,7,  1,0,3,0));  // retire r7, still full
        vq.push_back(mk(0,1, 0,0, 0,0,  1,7, 1, 0,0,  0,1,2,0));  // released
        vq.push_back(mk(0,1, 0,7, 1,7,  0,0, 1, 0,0,  1,0,3,0));  // rk hazard
        vq.push_back(mk(0,1, 0,7, 0,7,  0,0, 1, 0,0,  0,1,3,0));  // unused sources ignored
        vq.push_back(mk(0,1, 0,0, 0,0,  1,8, 0, 0,0,  0,0,3,0));  // ex_allowin=0: no inc
        vq.push_back(mk(0,1, 0,0, 1,7,  0,0, 0, 0,0,  1,0,3,0));  // stall computed anyway
        vq.push_back(mk(0,0, 1,7, 1,7,  1,7, 1, 0,0,  0,0,3,0));  // id_valid=0
        vq.push_back(mk(0,1, 0,0, 0,0,  1,9, 1, 0,0,  0,1,3,0));  // r9 writer
        vq.push_back(mk(0,1, 0,0, 0,0,  1,9, 1, 1,9,  0,1,4,0));  // issue+retire r9
        vq.push_back(mk(0,1, 0,0, 0,0,  1,9, 1, 1,7,  0,1,4,0));  // issue r9, retire r7
        vq.push_back(mk(0,1, 1,9, 0,0,  0,0, 1, 0,0,  1,0,4,0));  // cnt9=2
        vq.push_back(mk(0,0, 0,0, 0,0,  0,0, 1, 1,9,  0,0,4,0));  // retire r9
        vq.push_back(mk(0,1, 1,9, 0,0,  0,0, 1, 1,9,  1,0,3,0));  // last r9 retire
        vq.push_back(mk(0,1, 1,9, 0,0,  0,0, 1, 0,0,  0,1,2,0));  // released
        vq.push_back(mk(0,1, 1,0, 1,0,  1,0, 1, 0,0,  0,1,2,0));  // r0 everywhere
        vq.push_back(mk(0,1, 1,0, 1,0,  1,0, 1, 0,0,  0,1,2,0));  // no count for r0
        vq.push_back(mk(0,0, 0,0, 0,0,  0,0, 1, 1,0,  0,0,2,0));  // retire r0 ignored
        vq.push_back(mk(0,0, 0,0, 0,0,  0,0, 1, 0,0,  0,0,2,0));
        vq.push_back(mk(0,1, 0,0, 0,0,  1,4, 1, 0,0,  0,1,2,0));  // r4 writer
        vq.push_back(mk(0,1, 0,0, 0,0,  1,4, 1, 0,0,  0,1,3,0));  // cnt4 -> 2
        vq.push_back(mk(1,1, 0,0, 0,0,  1,4, 1, 0,0,  0,1,4,0));  // reset beats issue
        vq.push_back(mk(0,1, 1,4, 1,7,  0,0, 1, 0,0,  0,1,0,0));  // all cleared
        vq.push_back(mk(0,0, 0,0, 0,0,  0,0, 1, 1,12, 0,0,0,0));  // underflow r12
        vq.push_back(mk(0,0, 0,0, 0,0,  0,0, 1, 0,0,  0,0,-1,1));
        vq.push_back(mk(0,1, 1,12,0,0,  0,0, 1, 0,0,  0,1,-1,1)); // cnt12 still 0
        vq.push_back(mk(1,0, 0,0, 0,0,  0,0, 1, 0,0,  0,0,-1,1)); // sticky until reset
        vq.push_back(mk(0,0, 0,0, 0,0,  0,0, 1, 0,0,  0,0,0,0));

        idle.rst = 1'b1;
        drive(idle);
        repeat (2) @(negedge clk);
        #1;
        check("reset_inflight", int'(inflight), 0);
        check("reset_sb_error", int'(sb_error), 0);
        check("reset_stall", int'(id_stall), 0);
        check("reset_issue", int'(id_issue), 0);

        foreach (vq[i]) begin
            @(negedge clk);
            drive(vq[i]);
            #1;
            check($sformatf("v%0d_stall", i), int'(id_stall), int'(vq[i].e_stall));
            check($sformatf("v%0d_issue", i), int'(id_issue), int'(vq[i].e_issue));
            check($sformatf("v%0d_err", i), int'(sb_error), int'(vq[i].e_err));
            if (vq[i].e_infl >= 0)
                check($sformatf("v%0d_inflight", i), int'(inflight), vq[i].e_infl);
        end

        // Retire delay sweep: stall holds through the retire cycle, then clears.
        for (int d = 1; d <= 4; d++) begin
            vec_t v;
            @(negedge clk);
            v = mk(0,1, 0,0, 0,0, 1,20, 1, 0,0, 0,0,0,0);
            drive(v);
            #1;
            check($sformatf("sweep%0d_issue", d), int'(id_issue), 1);
            for (int k = 0; k <= d; k++) begin
                @(negedge clk);
                v = mk(0,1, 1,20, 0,0, 0,0, 1, (k == d-1), 20, 0,0,0,0);
                drive(v);
                #1;
                check($sformatf("sweep%0d_k%0d_stall", d, k), int'(id_stall), (k < d) ? 1 : 0);
            end
            check($sformatf("sweep%0d_inflight", d), int'(inflight), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rf_scoreboard.md
Name: rf_scoreboard

Overview:
- Register-file hazard controller for the 5-stage in-order pipeline (IF/ID/EX/ME/WB).
- Tracks, per architectural register, how many issued-but-unretired instructions will write it.
- Stalls ID while a source operand, or a destination counter at capacity, is pending.
- Counters increment when an instruction issues from ID to EX and decrement when WB retires a register write.
- Sits beside the ID stage; takes the WB-side write signals (the same ones that drive debug_wb_rf_we/wnum).

Parameters:
- NUM_REGS, 32, number of architectural registers; r0 is never tracked.
- CNT_W, 2, width of each pending counter; capacity is 2^CNT_W-1 writers in flight per register.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- id_valid  in  1  ID holds a valid instruction
- id_use_rj  in  1  instruction reads rj
- id_rj  in  5  first source register
- id_use_rk  in  1  instruction reads rk/rd (second source)
- id_rk  in  5  second source register
- id_rf_we  in  1  instruction writes the register file
- id_dest  in  5  destination register
- ex_allowin  in  1  EX can accept an instruction this cycle
- id_stall  out  1  ID must hold; combinational
- id_issue  out  1  id_valid & ~id_stall & ex_allowin; the ID->EX transfer fires
- wb_valid  in  1  WB holds a valid instruction this cycle
- wb_rf_we  in  1  WB instruction writes the register file
- wb_dest  in  5  WB destination
- inflight  out  4  registered count of tracked writers in flight
- sb_error  out  1  sticky; set on retire-underflow

Behaviour:
- State: cnt[1..NUM_REGS-1], each CNT_W bits; inflight; sb_error.
- Reset (synchronous, clk edge with reset=1): all cnt=0, inflight=0, sb_error=0. Reset overrides any same-cycle issue or retire.
- Reset consequence: id_stall=0 and id_issue=id_valid&ex_allowin immediately after reset.
- Register 0: reads of rj/rk==0 never stall. A dest of 0 is never counted, issued or retired.
- id_stall = id_valid & (hazard_j | hazard_k | dest_full).
  - hazard_j = id_use_rj & rj!=0 & cnt[rj]!=0.
  - hazard_k = id_use_rk & rk!=0 & cnt[rk]!=0.
  - dest_full = id_rf_we & dest!=0 & cnt[dest]==max.
- No forwarding is assumed: a source stays hazardous through the cycle WB retires it. It clears on the following cycle, when the register file holds the new value.
- inc = id_issue & id_rf_we & id_dest!=0.
- dec = wb_valid & wb_rf_we & wb_dest!=0.
- Counter update, applied at the clk edge:
  - inc only: cnt[id_dest]+1.
  - dec only: cnt[wb_dest]-1.
  - inc and dec on the same register: cnt unchanged.
  - inc and dec on different registers: both updates apply.
- inflight update: +1 on inc, -1 on dec, unchanged when both fire.
- Underflow: dec with cnt[wb_dest]==0 leaves the counter at 0 and sets sb_error=1. sb_error stays set until reset.
- Latency:
  - Issue of a writer to rX asserts stall for a reader of rX in ID on the next cycle.
  - Stall deasserts the cycle after the WB retire of the last writer.
- ex_allowin=0: id_stall is still computed, id_issue=0, and no inc occurs.
- id_valid=0: id_stall=0, id_issue=0.
- No other outputs are registered besides inflight and sb_error.

Test Plan:
- Reset, then ID holds add r4,r5,r6 with all counters 0 and ex_allowin=1 -> id_stall=0, id_issue=1. Next cycle cnt[r4]=1, inflight=1.
- Issue a write to r4, then next cycle present a reader of rj=r4 -> id_stall=1 until the cycle after wb_valid&wb_rf_we&wb_dest=4. Then id_stall=0 and inflight=0.
- Issue three back-to-back writers of r7 (no retire) -> cnt[r7]=3. A fourth writer of r7 gets id_stall=1 (dest_full). One WB retire of r7 releases it on the next cycle.
- Same cycle: issue a writer of r9 while WB retires r9 with cnt[r9]=1 -> cnt[r9] stays 1 and inflight is unchanged. Repeat with WB retiring r3 -> cnt[r9]=2, cnt[r3]-1.
- Reader with rj=0/rk=0, and a writer with dest=0 -> never stalls; inflight unchanged.
- Assert reset with cnt[r4]=2 and an issue firing -> next cycle all counters 0, inflight=0, id_stall=0.
- WB retire of r12 with cnt[r12]=0 -> sb_error=1 and remains 1 until reset.
